// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only L1 instruction cache with block refill
module icache #(
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_SIZE  = 8,
    parameter int MEM_SIZE    = 32,
    parameter int CACHE_LINES = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            cpu_ren,
    input  logic [$clog2(MEM_SIZE)+$clog2(BLOCK_SIZE)-1:0] cpu_addr,
    input  logic                            invalidate,
    output logic                            cpu_ready,
    output logic [WORD_SIZE-1:0]            cpu_dout,
    output logic                            mem_ren,
    output logic [$clog2(MEM_SIZE)-1:0]     mem_block_address,
    input  logic                            mem_ready,
    input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_din
);

    localparam int OFF_W = $clog2(BLOCK_SIZE);
    localparam int IDX_W = $clog2(CACHE_LINES);
    localparam int BA_W  = $clog2(MEM_SIZE);
    localparam int AW    = BA_W + OFF_W;
    localparam int TAG_W = BA_W - IDX_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                 state;
    logic [CACHE_LINES-1:0] valid;
    logic [TAG_W-1:0]       tags [CACHE_LINES];
    logic [WORD_SIZE-1:0]   lines [CACHE_LINES][BLOCK_SIZE];

    logic [OFF_W-1:0]       addr_off;
    logic [IDX_W-1:0]       addr_idx;
    logic [TAG_W-1:0]       addr_tag;
    logic [BA_W-1:0]        addr_block;
    logic [IDX_W-1:0]       fill_idx;
    logic [TAG_W-1:0]       fill_tag;
    logic                   hit;
    logic                   miss;
    logic                   fill_done;

    assign addr_off   = cpu_addr[OFF_W-1:0];
    assign addr_idx   = cpu_addr[OFF_W +: IDX_W];
    assign addr_tag   = cpu_addr[AW-1 -: TAG_W];
    assign addr_block = cpu_addr[AW-1:OFF_W];

    // The line being filled is addressed by the latched block address, so the
    // fill is immune to cpu_addr changing or cpu_ren dropping mid-fill.
    assign fill_idx  = mem_block_address[IDX_W-1:0];
    assign fill_tag  = mem_block_address[BA_W-1 -: TAG_W];
    assign fill_done = (state == FILL) && mem_ready;

    // Hit/miss decode; invalidate masks both so the flush cycle serves nothing.
    always_comb begin
        hit  = 1'b0;
        miss = 1'b0;
        if (state == IDLE && cpu_ren && !invalidate) begin
            hit  = valid[addr_idx] && (tags[addr_idx] == addr_tag);
            miss = !hit;
        end
    end

    // Zero-latency read port: word is driven straight out of the line on a hit.
    always_comb begin
        cpu_ready = hit;
        cpu_dout  = '0;
        if (hit) begin
            cpu_dout = lines[addr_idx][addr_off];
        end
    end

    // Control FSM: only state, valid bits and the memory request are reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            valid             <= '0;
            mem_ren           <= 1'b0;
            mem_block_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (invalidate) begin
                        valid <= '0;
                    end else if (miss) begin
                        mem_block_address <= addr_block;
                        mem_ren           <= 1'b1;
                        state             <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        valid[fill_idx] <= 1'b1;
                        mem_ren         <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; stale contents are masked by valid.
    always_ff @(posedge clock) begin
        if (fill_done) begin
            tags[fill_idx] <= fill_tag;
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                lines[fill_idx][k] <= mem_din[k*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

endmodule
